z16_wb_arbiter: RTL and testbench
=================================

# z16_wb_arbiter

Write-back arbiter and scoreboard for the Z16 register file's single write port. It accepts results from two producers, the ALU (A) and the load unit (M), through valid/ready handshakes. It grants one producer per cycle and drives the register file write port from a registered stage. It also keeps a per-register busy scoreboard so the issue stage can detect RAW and WAW hazards. It sits between the execute/memory stages and the register file write port.

## Interface
- No parameters. Widths are fixed at 16 registers and 16-bit data.
- i_clk  in  1  clock; all state updates on rising edge
- i_rst  in  1  synchronous, active-high reset
- i_a_valid  in  1  ALU result valid
- i_a_addr  in  4  ALU destination register
- i_a_data  in  16  ALU result
- o_a_ready  out  1  ALU result accepted this cycle
- i_m_valid  in  1  load result valid
- i_m_addr  in  4  load destination register
- i_m_data  in  16  load result
- o_m_ready  out  1  load result accepted this cycle
- i_issue_valid  in  1  instruction issuing with destination i_issue_rd
- i_issue_rd  in  4  destination of issuing instruction
- o_issue_ready  out  1  issue permitted (no WAW on i_issue_rd)
- i_rs1_addr  in  4  source 1 of instruction in issue
- i_rs2_addr  in  4  source 2 of instruction in issue
- o_rs1_hazard  out  1  source 1 pending write
- o_rs2_hazard  out  1  source 2 pending write
- o_rd_addr  out  4  to register file write address
- o_rd_we  out  1  to register file write enable
- o_rd_data  out  16  to register file write data
- o_busy  out  16  scoreboard, bit n = register n pending

## Operation
- Arbitration is combinational from the valid inputs and the priority state. At most one of o_a_ready and o_m_ready is high in a cycle. A ready is never high while its valid is low.
- Only one valid is high: that requester is granted.
- Both valids are high: the winner depends on the mode in Configuration.
- A grant is a transfer. At that edge, the address and data are captured into the output stage, and o_rd_we is set to 1 unless the address is 0.
- The output stage is not stalled, so there is no back-pressure beyond the arbitration loss.
- Scoreboard:
  - Set bit i_issue_rd when i_issue_valid and o_issue_ready are both high and i_issue_rd != 0.
  - Clear bit o_rd_addr when o_rd_we is high.
  - If a set and a clear hit the same register in the same cycle, the set wins.
  - Bit 0 is constant 0.
- o_issue_ready = ~busy[i_issue_rd]. An issuer facing a busy destination holds until the bit clears.
- o_rsN_hazard = busy[i_rsN_addr]. Register 0 never reports a hazard.
- A producer writing to a register whose busy bit is 0 is legal (untracked write). It clears nothing extra.

## Timing
- Reset values: o_rd_we=0, o_rd_addr=0, o_rd_data=0, o_busy=0, priority state points to A.
- Latency:
  - Cycle 0: transfer. Cycle 1: o_rd_* valid. Edge ending cycle 1: register file written, and the busy bit reads 0 in cycle 2.
- o_rsN_hazard, o_issue_ready and both ready outputs are combinational with no registered delay.
- o_rd_we is high for exactly one cycle per transfer. Back-to-back transfers give continuous o_rd_we.
- Reset asserted mid-operation: the in-flight output stage is dropped, with o_rd_we=0 in the next cycle. All busy bits clear, and no ready is asserted during reset.

## Configuration
- Z16_WB_RR_EN defined: round-robin arbitration.
  - A one-bit last-grant register sits in the priority state.
  - On a conflict, the requester not granted last wins.
  - The register updates on every transfer.
- Z16_WB_RR_EN undefined: fixed priority with M always winning conflicts. The last-grant register is not implemented.

## Test plan
- Reset, then idle: o_rd_we=0, o_busy=16'h0000, o_issue_ready=1, both hazards 0.
- Issue rd=3, then A sends addr=3 data=16'h1234 two cycles later:
  - o_busy[3]=1 from the cycle after issue.
  - o_rd_we=1, addr=3, data=16'h1234 one cycle after the transfer.
  - o_busy[3]=0 the cycle after that, and o_rs1_hazard for rs1=3 drops with it.
- Both valid for 4 cycles, addr A=1 and M=2:
  - With RR: grants are A, M, A, M.
  - Without RR: M is granted every cycle and o_a_ready stays 0.
- Issue rd=5 while busy[5]=1: o_issue_ready=0 and the bit is unchanged. The same cycle as the write-back clear of r5 sees a new issue to 5: busy[5] stays 1.
- A sends addr=0 data=16'hFFFF: o_a_ready=1, o_rd_we stays 0. Issue rd=0 leaves o_busy=0, and rs1=0 gives hazard 0.
- Transfer in flight, then i_rst high for 1 cycle: o_rd_we=0 the next cycle, o_busy=0, no register file write occurs.

Source files
------------

// File: rtl/z16_wb_arbiter_if.sv
// Write-back bus for z16_wb_arbiter: ALU/load result handshakes, issue hazard query, register file write port.
interface z16_wb_arbiter_if;
  logic        i_a_valid;
  logic [3:0]  i_a_addr;
  logic [15:0] i_a_data;
  logic        o_a_ready;
  logic        i_m_valid;
  logic [3:0]  i_m_addr;
  logic [15:0] i_m_data;
  logic        o_m_ready;
  logic        i_issue_valid;
  logic [3:0]  i_issue_rd;
  logic        o_issue_ready;
  logic [3:0]  i_rs1_addr;
  logic [3:0]  i_rs2_addr;
  logic        o_rs1_hazard;
  logic        o_rs2_hazard;
  logic [3:0]  o_rd_addr;
  logic        o_rd_we;
  logic [15:0] o_rd_data;
  logic [15:0] o_busy;

  modport slave (
    input  i_a_valid, i_a_addr, i_a_data,
    output o_a_ready,
    input  i_m_valid, i_m_addr, i_m_data,
    output o_m_ready,
    input  i_issue_valid, i_issue_rd,
    output o_issue_ready,
    input  i_rs1_addr, i_rs2_addr,
    output o_rs1_hazard, o_rs2_hazard,
    output o_rd_addr, o_rd_we, o_rd_data, o_busy
  );

  modport master (
    output i_a_valid, i_a_addr, i_a_data,
    input  o_a_ready,
    output i_m_valid, i_m_addr, i_m_data,
    input  o_m_ready,
    output i_issue_valid, i_issue_rd,
    input  o_issue_ready,
    output i_rs1_addr, i_rs2_addr,
    input  o_rs1_hazard, o_rs2_hazard,
    input  o_rd_addr, o_rd_we, o_rd_data, o_busy
  );
endinterface

// File: rtl/z16_wb_arbiter.sv
// Write-back arbiter + busy scoreboard: one-cycle registered write port, losers stall via ready only.
// Conflicts go to M (fixed priority) unless Z16_WB_RR_EN selects round-robin.
module z16_wb_arbiter (
  input logic             i_clk,
  input logic             i_rst,
  z16_wb_arbiter_if.slave bus
);
  logic        prefer_m;
  logic        grant_a;
  logic        grant_m;
  logic [3:0]  win_addr;
  logic [15:0] win_data;
  logic        rd_we;
  logic [3:0]  rd_addr;
  logic [15:0] rd_data;
  logic [15:0] busy;
  logic [15:0] set_vec;
  logic [15:0] clr_vec;
  logic        issue_fire;

`ifdef Z16_WB_RR_EN
  // Holds "A won the last transfer"; reset value makes A the first conflict winner.
  logic last_a;
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      last_a <= 1'b0;
    end else if (grant_a || grant_m) begin
      last_a <= grant_a;
    end
  end
  assign prefer_m = last_a;
`else
  assign prefer_m = 1'b1;
`endif

  always_comb begin
    grant_a  = !i_rst && bus.i_a_valid && (!bus.i_m_valid || !prefer_m);
    grant_m  = !i_rst && bus.i_m_valid && (!bus.i_a_valid ||  prefer_m);
    win_addr = grant_m ? bus.i_m_addr : bus.i_a_addr;
    win_data = grant_m ? bus.i_m_data : bus.i_a_data;
  end

  assign bus.o_a_ready = grant_a;
  assign bus.o_m_ready = grant_m;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      rd_we   <= 1'b0;
      rd_addr <= 4'd0;
      rd_data <= 16'd0;
    end else if (grant_a || grant_m) begin
      rd_we   <= (win_addr != 4'd0);
      rd_addr <= win_addr;
      rd_data <= win_data;
    end else begin
      rd_we   <= 1'b0;
    end
  end

  assign bus.o_rd_we   = rd_we;
  assign bus.o_rd_addr = rd_addr;
  assign bus.o_rd_data = rd_data;

  assign issue_fire = bus.i_issue_valid && bus.o_issue_ready && (bus.i_issue_rd != 4'd0);

  always_comb begin
    set_vec = issue_fire ? (16'h0001 << bus.i_issue_rd) : 16'h0000;
    clr_vec = rd_we      ? (16'h0001 << rd_addr)        : 16'h0000;
  end

  // Set is OR'd after the clear so a same-cycle issue to the written register stays pending.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      busy <= 16'h0000;
    end else begin
      busy <= ((busy & ~clr_vec) | set_vec) & 16'hFFFE;
    end
  end

  assign bus.o_busy        = busy;
  assign bus.o_issue_ready = ~busy[bus.i_issue_rd];
  assign bus.o_rs1_hazard  = busy[bus.i_rs1_addr];
  assign bus.o_rs2_hazard  = busy[bus.i_rs2_addr];
endmodule

// File: tb/tb_z16_wb_arbiter.sv
// Self-checking bench for z16_wb_arbiter: vector table plus hand sequences, write-back scoreboard queue.
module tb_z16_wb_arbiter;
  logic i_clk = 1'b0;
  logic i_rst;
  always #5 i_clk = ~i_clk;

  z16_wb_arbiter_if bus ();

  z16_wb_arbiter dut (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .bus   (bus)
  );

`ifdef Z16_WB_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic        we;
    logic [3:0]  addr;
    logic [15:0] data;
  } wb_t;
  wb_t exp_q[$];

  typedef struct {
    logic av; logic [3:0] aa; logic [15:0] ad;
    logic mv; logic [3:0] ma; logic [15:0] md;
    logic iv; logic [3:0] ird;
    logic [3:0] rs1; logic [3:0] rs2;
    logic ar; logic mr; logic ir; logic h1; logic h2;
  } vec_t;
  vec_t vec[9];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic set_in(input logic av, input logic [3:0] aa, input logic [15:0] ad,
                        input logic mv, input logic [3:0] ma, input logic [15:0] md,
                        input logic iv, input logic [3:0] ird,
                        input logic [3:0] rs1, input logic [3:0] rs2);
    bus.i_a_valid = av; bus.i_a_addr = aa; bus.i_a_data = ad;
    bus.i_m_valid = mv; bus.i_m_addr = ma; bus.i_m_data = md;
    bus.i_issue_valid = iv; bus.i_issue_rd = ird;
    bus.i_rs1_addr = rs1; bus.i_rs2_addr = rs2;
  endtask

  // Called 1 time unit after a rising edge with inputs already driven.
  task automatic tick(input logic ear, input logic emr, input string tag);
    wb_t e;
    wb_t got;
    #3;
    chk({tag, "_a_ready"}, 32'(bus.o_a_ready), 32'(ear));
    chk({tag, "_m_ready"}, 32'(bus.o_m_ready), 32'(emr));
    e.we = 1'b0; e.addr = 4'd0; e.data = 16'd0;
    if (ear) begin
      e.we = (bus.i_a_addr != 4'd0); e.addr = bus.i_a_addr; e.data = bus.i_a_data;
    end else if (emr) begin
      e.we = (bus.i_m_addr != 4'd0); e.addr = bus.i_m_addr; e.data = bus.i_m_data;
    end
    exp_q.push_back(e);
    @(posedge i_clk);
    #1;
    got = exp_q.pop_front();
    chk({tag, "_rd_we"}, 32'(bus.o_rd_we), 32'(got.we));
    if (got.we) begin
      chk({tag, "_rd_addr"}, 32'(bus.o_rd_addr), 32'(got.addr));
      chk({tag, "_rd_data"}, 32'(bus.o_rd_data), 32'(got.data));
    end
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

  initial begin
    // Writes here are untracked except r7; conflict rows follow an M grant so RR starts with A.
    vec[0] = '{1'b0, 4'd0, 16'h0000, 1'b0, 4'd0, 16'h0000, 1'b1, 4'd7, 4'd7, 4'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    vec[1] = '{1'b1, 4'd7, 16'h0007, 1'b0, 4'd0, 16'h0000, 1'b1, 4'd7, 4'd7, 4'd2, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    vec[2] = '{1'b0, 4'd0, 16'h0000, 1'b1, 4'd9, 16'hBEEF, 1'b0, 4'd7, 4'd2, 4'd7, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    vec[3] = '{1'b0, 4'd0, 16'h0000, 1'b0, 4'd0, 16'h0000, 1'b0, 4'd7, 4'd7, 4'd9, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    vec[4] = '{1'b1, 4'd1, 16'h1111, 1'b1, 4'd2, 16'h2222, 1'b0, 4'd0, 4'd0, 4'd0, RR,   !RR,  1'b1, 1'b0, 1'b0};
    vec[5] = '{1'b1, 4'd1, 16'h1112, 1'b1, 4'd2, 16'h2223, 1'b0, 4'd0, 4'd0, 4'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    vec[6] = '{1'b1, 4'd1, 16'h1113, 1'b1, 4'd2, 16'h2224, 1'b0, 4'd0, 4'd0, 4'd0, RR,   !RR,  1'b1, 1'b0, 1'b0};
    vec[7] = '{1'b1, 4'd1, 16'h1114, 1'b1, 4'd2, 16'h2225, 1'b0, 4'd0, 4'd0, 4'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    vec[8] = '{1'b0, 4'd0, 16'h0000, 1'b0, 4'd0, 16'h0000, 1'b0, 4'd0, 4'd1, 4'd2, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};

    i_rst = 1'b1;
    set_in(1'b0, 4'd0, 16'h0, 1'b0, 4'd0, 16'h0, 1'b0, 4'd0, 4'd0, 4'd0);
    repeat (2) @(posedge i_clk);
    #1;
    chk("rst_rd_we", 32'(bus.o_rd_we), 32'd0);
    chk("rst_rd_addr", 32'(bus.o_rd_addr), 32'd0);
    chk("rst_rd_data", 32'(bus.o_rd_data), 32'd0);
    chk("rst_busy", 32'(bus.o_busy), 32'h0000);
    i_rst = 1'b0;
    #2;
    chk("idle_issue_ready", 32'(bus.o_issue_ready), 32'd1);
    chk("idle_rs1_haz", 32'(bus.o_rs1_hazard), 32'd0);
    chk("idle_rs2_haz", 32'(bus.o_rs2_hazard), 32'd0);
    tick(1'b0, 1'b0, "idle");

    // Issue r3, then ALU writes it two cycles later.
    set_in(1'b0, 4'd0, 16'h0, 1'b0, 4'd0, 16'h0, 1'b1, 4'd3, 4'd3, 4'd0);
    tick(1'b0, 1'b0, "iss3");
    chk("iss3_busy", 32'(bus.o_busy), 32'h0008);
    set_in(1'b0, 4'd0, 16'h0, 1'b0, 4'd0, 16'h0, 1'b0, 4'd0, 4'd3, 4'd0);
    #2;
    chk("iss3_haz", 32'(bus.o_rs1_hazard), 32'd1);
    tick(1'b0, 1'b0, "gap3");
    set_in(1'b1, 4'd3, 16'h1234, 1'b0, 4'd0, 16'h0, 1'b0, 4'd0, 4'd3, 4'd0);
    tick(1'b1, 1'b0, "wb3");
    set_in(1'b0, 4'd0, 16'h0, 1'b0, 4'd0, 16'h0, 1'b0, 4'd0, 4'd3, 4'd0);
    #2;
    chk("wb3_busy_held", 32'(bus.o_busy), 32'h0008);
    chk("wb3_haz_held", 32'(bus.o_rs1_hazard), 32'd1);
    tick(1'b0, 1'b0, "clr3");
    chk("clr3_busy", 32'(bus.o_busy), 32'h0000);
    chk("clr3_haz", 32'(bus.o_rs1_hazard), 32'd0);

    for (int i = 0; i < 9; i++) begin
      string tag;
      tag = $sformatf("vec%0d", i);
      set_in(vec[i].av, vec[i].aa, vec[i].ad, vec[i].mv, vec[i].ma, vec[i].md,
             vec[i].iv, vec[i].ird, vec[i].rs1, vec[i].rs2);
      #2;
      chk({tag, "_issue_ready"}, 32'(bus.o_issue_ready), 32'(vec[i].ir));
      chk({tag, "_rs1_haz"}, 32'(bus.o_rs1_hazard), 32'(vec[i].h1));
      chk({tag, "_rs2_haz"}, 32'(bus.o_rs2_hazard), 32'(vec[i].h2));
      tick(vec[i].ar, vec[i].mr, tag);
    end
    chk("vec_busy_end", 32'(bus.o_busy), 32'h0000);

    // Untracked write to r5 coinciding with a new issue to r5: the set survives.
    set_in(1'b1, 4'd5, 16'h5555, 1'b0, 4'd0, 16'h0, 1'b0, 4'd0, 4'd0, 4'd0);
    tick(1'b1, 1'b0, "u5");
    set_in(1'b0, 4'd0, 16'h0, 1'b0, 4'd0, 16'h0, 1'b1, 4'd5, 4'd5, 4'd0);
    #2;
    chk("u5_issue_ready", 32'(bus.o_issue_ready), 32'd1);
    tick(1'b0, 1'b0, "set5");
    chk("set5_busy", 32'(bus.o_busy), 32'h0020);
    #2;
    chk("busy5_issue_ready", 32'(bus.o_issue_ready), 32'd0);
    tick(1'b0, 1'b0, "hold5");
    chk("hold5_busy", 32'(bus.o_busy), 32'h0020);
    set_in(1'b1, 4'd5, 16'hA5A5, 1'b0, 4'd0, 16'h0, 1'b0, 4'd0, 4'd0, 4'd0);
    tick(1'b1, 1'b0, "wb5");
    set_in(1'b0, 4'd0, 16'h0, 1'b0, 4'd0, 16'h0, 1'b0, 4'd0, 4'd0, 4'd0);
    tick(1'b0, 1'b0, "clr5");
    chk("clr5_busy", 32'(bus.o_busy), 32'h0000);

    // Writes and issues to r0 are discarded.
    set_in(1'b1, 4'd0, 16'hFFFF, 1'b0, 4'd0, 16'h0, 1'b1, 4'd0, 4'd0, 4'd0);
    tick(1'b1, 1'b0, "r0");
    chk("r0_busy", 32'(bus.o_busy), 32'h0000);
    chk("r0_haz", 32'(bus.o_rs1_hazard), 32'd0);

    // Reset while a write-back is in the output stage.
    set_in(1'b1, 4'd4, 16'h4444, 1'b0, 4'd0, 16'h0, 1'b1, 4'd4, 4'd0, 4'd0);
    tick(1'b1, 1'b0, "pre_rst");
    chk("pre_rst_busy", 32'(bus.o_busy), 32'h0010);
    i_rst = 1'b1;
    set_in(1'b1, 4'd6, 16'h6666, 1'b1, 4'd8, 16'h8888, 1'b0, 4'd0, 4'd0, 4'd0);
    tick(1'b0, 1'b0, "mid_rst");
    chk("mid_rst_busy", 32'(bus.o_busy), 32'h0000);
    i_rst = 1'b0;
    set_in(1'b0, 4'd0, 16'h0, 1'b0, 4'd0, 16'h0, 1'b0, 4'd0, 4'd4, 4'd0);
    tick(1'b0, 1'b0, "post_rst");
    chk("post_rst_haz", 32'(bus.o_rs1_hazard), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
